// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM arbiter.
// Optional round-robin arbitration: define SRAM_ARB_RR_EN.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE, RD, WS, WP, WH, ACK
  } state_t;

  typedef enum logic {
    GNT_IF, GNT_MEM
  } grant_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter with zero flag.
// Paces the timed SRAM phases.
module sram_wait_cnt
  import sram_arb_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load on phase entry, then count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for one async SRAM bank.
// Optional round-robin arbitration: define SRAM_ARB_RR_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output logic              busy
);

  localparam int CW = $clog2(max2(RD_WAIT, WR_WAIT) + 1);
  localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT);
  localparam logic [CW-1:0] WP_LD = CW'(WR_WAIT - 1);

  state_t            state, state_n;
  grant_t            gnt, gnt_n;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              pick_mem;
  logic              cnt_load, cnt_zero;
  logic [CW-1:0]     cnt_val;
  logic              rd_n, wr_n;

`ifdef SRAM_ARB_RR_EN
  grant_t last_grant;
`endif

  sram_wait_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Arbitrate in IDLE and sequence the access phases
  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    be_d     = be_q;
    addr_d   = sram_addr;
    wdata_d  = sram_dq_o;
    pick_mem = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state)
      IDLE: begin
`ifdef SRAM_ARB_RR_EN
        pick_mem = mem_req &&
                   (!if_req || last_grant == GNT_IF);
`else
        pick_mem = mem_req;
`endif
        if (mem_req || if_req) begin
          gnt_n  = pick_mem ? GNT_MEM : GNT_IF;
          addr_d = pick_mem ? mem_addr : if_addr;
          if (pick_mem && mem_we) begin
            state_n = WS;
            wdata_d = mem_wdata;
            be_d    = mem_be;
          end else begin
            state_n  = RD;
            cnt_load = 1'b1;
            cnt_val  = RD_LD;
          end
        end
      end
      RD:  if (cnt_zero) state_n = ACK;
      WS: begin
        state_n  = WP;
        cnt_load = 1'b1;
        cnt_val  = WP_LD;
      end
      WP:  if (cnt_zero) state_n = WH;
      WH:  state_n = ACK;
      ACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rd_n = (state_n == RD);
  assign wr_n = (state_n == WS) ||
                (state_n == WP) ||
                (state_n == WH);
  assign busy = (state != IDLE);

  // Register state, pins, acks and captured read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= GNT_IF;
      be_q       <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      be_q       <= be_d;
      sram_addr  <= addr_d;
      sram_dq_o  <= wdata_d;
      sram_dq_oe <= wr_n;
      sram_ce_n  <= !(rd_n || wr_n);
      sram_oe_n  <= !rd_n;
      sram_we_n  <= (state_n != WP);
      sram_be_n  <= rd_n ? 4'h0 :
                    (wr_n ? ~be_d : 4'hF);
      if_ack     <= (state_n == ACK) &&
                    (gnt == GNT_IF);
      mem_ack    <= (state_n == ACK) &&
                    (gnt == GNT_MEM);
      if (state == RD && cnt_zero) begin
        if (gnt == GNT_MEM)
          mem_rdata <= sram_dq_i;
        else
          if_rdata  <= sram_dq_i;
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Remember the latest winner for round-robin
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= GNT_IF;
    else if (state == IDLE && (if_req || mem_req))
      last_grant <= gnt_n;
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with an SRAM model.
// Covers SRAM_ARB_RR_EN defined or undefined.
module tb_sram_arbiter;

  localparam int RDW = 1;
  localparam int WRW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req = 1'b0;
  logic [19:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_be = '0;
  logic [19:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_i;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic        busy;

  sram_arbiter #(
    .ADDR_W(20), .DATA_W(32),
    .RD_WAIT(RDW), .WR_WAIT(WRW)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] d;
  } mexp_t;

  logic [31:0] if_q[$];
  mexp_t       mem_q[$];
  int          ack_log[$];
  logic [31:0] ref_mem [logic [19:0]];

  function automatic logic [31:0] init_val(logic [19:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] model_rd(logic [19:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic model_wr(input logic [19:0] a,
                          input logic [31:0] d,
                          input logic [3:0] be);
    logic [31:0] cur;
    cur = model_rd(a);
    for (int b = 0; b < 4; b++)
      if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = cur;
  endtask

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Board SRAM: async read, byte-masked write while we_n low
  logic [31:0] sram_mem [0:65535];
  bit          sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 65536; i++)
        sram_mem[i] <= init_val(20'(i));
      sram_init <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b])
          sram_mem[sram_addr[15:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
    end
  end
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ?
                     sram_mem[sram_addr[15:0]] : 32'hBAD0BAD0;

  // Monitor: pops expectations on acks, checks bus invariants
  logic prev_oe_n = 1'b1;
  logic prev_dq_oe = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_oe_n  = 1'b1;
      prev_dq_oe = 1'b0;
    end else begin
      if (if_ack) begin
        ack_log.push_back(0);
        if (if_q.size() == 0) check("if_ack_expected", 0, 1);
        else check("if_rdata", if_rdata, if_q.pop_front());
      end
      if (mem_ack) begin
        mexp_t e;
        ack_log.push_back(1);
        if (mem_q.size() == 0) check("mem_ack_expected", 0, 1);
        else begin
          e = mem_q.pop_front();
          if (!e.we) check("mem_rdata", mem_rdata, e.d);
        end
      end
      if (if_ack || mem_ack) begin
        check("ack_bus_idle",
              {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe},
              4'b1110);
        check("ack_exclusive", if_ack && mem_ack, 0);
      end
      if (!sram_oe_n && prev_oe_n)
        check("turnaround", prev_dq_oe, 0);
      prev_oe_n  = sram_oe_n;
      prev_dq_oe = sram_dq_oe;
    end
  end

  task automatic wait_ack(input bit is_mem);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_mem ? mem_ack : if_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(is_mem ? "mem_ack_timeout" : "if_ack_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic if_issue(input logic [19:0] a);
    if_addr = a;
    if_req  = 1'b1;
    if_q.push_back(model_rd(a));
  endtask

  task automatic mem_issue(input logic we, input logic [19:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    mem_we = we; mem_addr = a; mem_wdata = d; mem_be = be;
    mem_req = 1'b1;
    if (we) begin
      model_wr(a, d, be);
      mem_q.push_back('{we: 1'b1, d: 32'h0});
    end else
      mem_q.push_back('{we: 1'b0, d: model_rd(a)});
  endtask

  task automatic if_run(input int n, input int gmax);
    for (int k = 0; k < n; k++) begin
      if_issue(20'($urandom_range(0, 127)));
      wait_ack(1'b0);
      if (gmax > 0) begin
        if_req = 1'b0;
        repeat ($urandom_range(0, gmax)) @(posedge clk);
        #1;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic mem_run(input int n, input int gmax, input bit wr_ok);
    for (int k = 0; k < n; k++) begin
      mem_issue(wr_ok ? 1'($urandom_range(0, 1)) : 1'b0,
                20'($urandom_range(128, 255)),
                $urandom, 4'($urandom));
      wait_ack(1'b1);
      if (gmax > 0) begin
        mem_req = 1'b0;
        repeat ($urandom_range(0, gmax)) @(posedge clk);
        #1;
      end
    end
    mem_req = 1'b0;
  endtask

  function automatic logic [15:0] msk(int lo, int hi);
    logic [15:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Per-cycle pin trace; cycle 0 is the cycle the request is sampled
  logic [15:0] t_oe, t_ce, t_we, t_dq, t_ack;
  logic [3:0]  t_be2;
  task automatic trace(input bit is_mem);
    t_oe = '0; t_ce = '0; t_we = '0; t_dq = '0; t_ack = '0; t_be2 = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      t_oe[c]  = !sram_oe_n;
      t_ce[c]  = !sram_ce_n;
      t_we[c]  = !sram_we_n;
      t_dq[c]  = sram_dq_oe;
      t_ack[c] = is_mem ? mem_ack : if_ack;
      if (c == 2) t_be2 = sram_be_n;
      @(posedge clk); #1;
      if (t_ack[c]) begin
        if_req  = 1'b0;
        mem_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    if_q.delete();
    mem_q.delete();
  endtask

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int mc, ic;
    logic [7:0]  got8, exp8;
    logic [31:0] iv;
    bit ok;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_ctrl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    check("rst_be_n", sram_be_n, 4'hF);
    check("rst_addr_dq", {sram_addr, sram_dq_o}, 0);
    check("rst_acks_busy", {if_ack, mem_ack, busy}, 0);
    check("rst_rdata", {if_rdata, mem_rdata}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset during the write pulse aborts the access
    @(posedge clk); #1;
    mem_we = 1'b1; mem_addr = 20'h00123;
    mem_wdata = 32'hA1B2C3D4; mem_be = 4'hF; mem_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_we_n) begin ok = 1'b1; break; end
    end
    check("rst_reach_wp", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("rstwp_ctrl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    check("rstwp_be_n", sram_be_n, 4'hF);
    check("rstwp_ack", {if_ack, mem_ack, busy}, 0);
    mem_req = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    mem_issue(1'b1, 20'h00123, 32'hA1B2C3D4, 4'hF);
    wait_ack(1'b1);
    mem_req = 1'b0;
    mem_issue(1'b0, 20'h00123, 0, 0);
    wait_ack(1'b1);
    mem_req = 1'b0;
    check("rst_restart_data", mem_rdata, 32'hA1B2C3D4);

    // Fetch read timing
    mem_issue(1'b1, 20'h00010, 32'h12345678, 4'hF);
    wait_ack(1'b1);
    mem_req = 1'b0;
    @(posedge clk); #1;
    if_issue(20'h00010);
    trace(1'b0);
    check("rd_oe_mask", t_oe, msk(1, RDW + 1));
    check("rd_ce_mask", t_ce, msk(1, RDW + 1));
    check("rd_ack_mask", t_ack, msk(RDW + 2, RDW + 2));
    check("rd_dq_oe_mask", t_dq, 0);
    check("rd_if_rdata", if_rdata, 32'h12345678);

    // Data write timing and byte masking
    @(posedge clk); #1;
    mem_issue(1'b1, 20'h0ABCD, 32'hDEADBEEF, 4'b0011);
    trace(1'b1);
    check("wr_dq_oe_mask", t_dq, msk(1, WRW + 2));
    check("wr_ce_mask", t_ce, msk(1, WRW + 2));
    check("wr_we_mask", t_we, msk(2, WRW + 1));
    check("wr_oe_mask", t_oe, 0);
    check("wr_ack_mask", t_ack, msk(WRW + 3, WRW + 3));
    check("wr_be_n", t_be2, 4'b1100);
    mem_issue(1'b0, 20'h0ABCD, 0, 0);
    wait_ack(1'b1);
    mem_req = 1'b0;
    iv = init_val(20'h0ABCD);
    check("wr_low16", mem_rdata[15:0], 16'hBEEF);
    check("wr_high16_kept", mem_rdata[31:16], iv[31:16]);

    // Write then fetch read back-to-back
    mem_issue(1'b1, 20'h0ABCD, 32'hCAFEF00D, 4'b1100);
    wait_ack(1'b1);
    mem_req = 1'b0;
    if_issue(20'h0ABCD);
    wait_ack(1'b0);
    if_req = 1'b0;
    check("wr_rd_back", if_rdata, 32'hCAFEBEEF);

    // Simultaneous requests: mem first, fetch after the gap
    @(posedge clk); #1;
    mem_issue(1'b0, 20'h00123, 0, 0);
    if_issue(20'h00010);
    mc = -1; ic = -1;
    for (int c = 0; c < 60 && (mc < 0 || ic < 0); c++) begin
      @(negedge clk);
      if (mem_ack) mc = c;
      if (if_ack) ic = c;
      @(posedge clk); #1;
      if (mc >= 0) mem_req = 1'b0;
      if (ic >= 0) if_req = 1'b0;
    end
    check("arb_mem_first", (mc >= 0) && (mc < ic), 1);
    check("arb_if_gap", ic - mc, RDW + 3);

    // Randomized concurrent traffic
    fork
      if_run(30, 3);
      mem_run(30, 3, 1'b1);
    join

    // Both requests held continuously
    @(posedge clk); #1;
    do_reset();
    ack_log.delete();
    @(posedge clk); #1;
    fork
      if_run(4, 0);
      mem_run(4, 0, 1'b0);
    join
    check("hold_ack_count", ack_log.size(), 8);
    got8 = '0;
    for (int k = 0; k < 8 && k < ack_log.size(); k++)
      got8[k] = ack_log[k][0];
`ifdef SRAM_ARB_RR_EN
    exp8 = 8'b0101_0101;
`else
    exp8 = 8'b0000_1111;
`endif
    check("hold_grant_order", got8, exp8);

    repeat (5) @(posedge clk);
    check("if_q_drained", if_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
